aes_encipher_iter: RTL and testbench
====================================

Name: aes_encipher_iter

Overview:
- Iterative AES encipher datapath with a round-sequencing FSM.
- Performs the initial AddRoundKey, Nr-1 main rounds and the final round (no MixColumns) on one 128-bit block.
- Supports AES-128 (Nr=10) and AES-256 (Nr=14), selected per block. S-box parallelism is a parameter for area/speed trade-off.
- Sits between the core control/API layer and the key memory. The key memory serves round keys combinationally, indexed by the round output.

Parameters:
- SBOX_PAR, 16, number of parallel S-box lanes. Legal values are 16 (one cycle per round) or 4 (one column per cycle, four cycles per round).
- Any other value stops elaboration via a generate-time error.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- next  input  1  start pulse. Accepted only when ready=1.
- keylen  input  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14). Sampled when next is accepted.
- block  input  128  plaintext, byte 0 in [127:120], column-major. Sampled when next is accepted.
- round  output  4  index of the round key required this cycle (0..Nr).
- round_key  input  128  round key for the current round index. Valid in the same cycle (combinational key memory).
- new_block  output  128  ciphertext. Holds the state register; meaningful when result_valid=1.
- ready  output  1  1 = idle, can accept next.
- result_valid  output  1  set on completion, cleared on the next accepted start.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FSM goes to IDLE.
  - ready=1, result_valid=0, round=0, new_block=128'h0, internal column counter=0.
  - Reset mid-operation aborts the block with no partial output flagged.
- FSM states: IDLE, INIT, ROUND, DONE.
- IDLE:
  - round=0.
  - next=1 → latch block and keylen, clear result_valid, ready←0, go to INIT.
- INIT (1 cycle):
  - round=0; state ← block ^ round_key.
  - round_ctr←1, col_ctr←0, go to ROUND.
- ROUND, SBOX_PAR=16:
  - One cycle per round.
  - state ← AddRoundKey(MixColumns(ShiftRows(SubBytes(state)))), with MixColumns skipped when round_ctr==Nr.
- ROUND, SBOX_PAR=4:
  - Four cycles per round.
  - col_ctr=0..3: SubBytes on column col_ctr into a 128-bit substitution buffer.
  - At col_ctr=3: ShiftRows/MixColumns/AddRoundKey apply to the completed buffer (including the column substituted this cycle) and write state.
  - round_key is sampled only in the col_ctr=3 cycle; round output is stable for all four cycles.
- Round counter:
  - After the round update, round_ctr==Nr → go to DONE; otherwise round_ctr+1. col_ctr wraps 3→0.
  - round output equals round_ctr in ROUND.
- DONE (1 cycle): result_valid←1, ready←1, round←0, go to IDLE.
- Latency, next-accept edge to ready=1: 2 + Nr·(16/SBOX_PAR) cycles.
  - SBOX_PAR=16: AES-128 = 12, AES-256 = 16.
  - SBOX_PAR=4: AES-128 = 42, AES-256 = 58.
- Input rules:
  - next while ready=0 is ignored; the current operation is unaffected.
  - Changes to keylen or block during processing are ignored.
- Completion and back-to-back:
  - next asserted in the same cycle DONE→IDLE is not accepted (ready still 0 that cycle).
  - new_block holds its value after DONE until the following INIT overwrites it.
- GF arithmetic:
  - gmul2(x) = {x[6:0],0} ^ (8'h1b & {8{x[7]}}); gmul3 = gmul2 ^ x.
  - All byte operations are 8-bit, no carries.
- Byte mapping: state byte s[r][c] = word c, byte r. Round key bits [127-32c-8r -: 8] XOR into s[r][c].

Decomposition:
- Shared package aes_pkg:
  - Nr constants (AES128_ROUNDS=10, AES256_ROUNDS=14) and keylen encodings.
  - FSM state encoding.
  - gmul2/gmul3/mixcolumn-word functions, shared later by the decipher counterpart.
- Sub-module: reuse aes_sbox, SBOX_PAR instances in a generate loop.
- ShiftRows/MixColumns stay inline.

Test Plan:
- FIPS-197 C.1, keylen=0, SBOX_PAR=16:
  - Stimulus: key 000102…0f (bench model expands round keys), block 00112233445566778899aabbccddeeff.
  - Required: new_block=69c4e0d86a7b0430d8cdb78070b4c55a; ready high exactly 12 cycles after next; result_valid=1.
- FIPS-197 C.3, keylen=1:
  - Stimulus: key 000102…1f, same plaintext.
  - Required: new_block=8ea2b7ca516745bfeafc49904b496089; latency 16 (SBOX_PAR=16) and 58 (SBOX_PAR=4).
- Round index trace, SBOX_PAR=4, AES-128:
  - Required: round=0 for 1 cycle, then each value 1..10 held exactly 4 cycles, then 0.
- next pulsed at cycle 5 of a busy operation with a different block:
  - Required: ignored; result is still 69c4e0d8…c55a.
- Reset mid-operation:
  - Stimulus: reset_n low at round 6, then a fresh C.1 run.
  - Required: during reset ready=1, result_valid=0, new_block=0; the fresh run produces the correct ciphertext.
- Back-to-back:
  - Stimulus: next held high continuously.
  - Required: a new operation starts only in the cycle after ready=1. result_valid drops when the new start is accepted and rises again on completion.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: round counts, key-length and FSM encodings,
// and the GF(2^8) helpers used by the encipher (and later decipher) datapaths.
package aes_pkg;

    localparam logic [3:0] AES128_ROUNDS = 4'd10;
    localparam logic [3:0] AES256_ROUNDS = 4'd14;

    typedef enum logic {
        KEYLEN_128 = 1'b0,
        KEYLEN_256 = 1'b1
    } keylen_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } aes_state_e;

    function automatic logic [7:0] gmul2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return gmul2(x) ^ x;
    endfunction

    // Word is one state column, row 0 in the top byte.
    function automatic logic [31:0] mixcolumn_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gmul2(b0) ^ gmul3(b1) ^ b2 ^ b3,
                b0 ^ gmul2(b1) ^ gmul3(b2) ^ b3,
                b0 ^ b1 ^ gmul2(b2) ^ gmul3(b3),
                gmul3(b0) ^ b1 ^ b2 ^ gmul2(b3)};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform, computed rather than tabulated.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gmul2(sh);
        end
        return acc;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Inverse as x^254 (maps 0 to 0, as the S-box requires).
    always_comb begin
        x2   = gf_mul(in_i, in_i);
        x3   = gf_mul(x2, in_i);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
    end

    assign out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_encipher_iter.sv
// Iterative AES-128/256 encipher: INIT applies round key 0, then one round per
// cycle (SBOX_PAR=16) or one column per cycle (SBOX_PAR=4), final round w/o MixColumns.
module aes_encipher_iter
    import aes_pkg::*;
#(
    parameter int SBOX_PAR = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         result_valid
);

    localparam int SB_W = 8 * SBOX_PAR;

    aes_state_e   state_q, state_d;
    keylen_e      keylen_q, keylen_d;
    logic [127:0] block_q, block_d;
    logic [127:0] data_q, data_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic [1:0]   col_ctr_q, col_ctr_d;
    logic         valid_q, valid_d;

    logic [3:0]    nr;
    logic [SB_W-1:0] sb_in, sb_out;
    logic [127:0]  sub_full, shifted, mixed, round_out;
    logic          round_step;

    assign nr = (keylen_q == KEYLEN_256) ? AES256_ROUNDS : AES128_ROUNDS;

    genvar gi;
    for (gi = 0; gi < SBOX_PAR; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (sb_in[8*gi +: 8]),
            .out_o (sb_out[8*gi +: 8])
        );
    end

    if (SBOX_PAR == 16) begin : g_full
        assign sb_in      = data_q;
        assign sub_full   = sb_out;
        assign round_step = 1'b1;
    end else if (SBOX_PAR == 4) begin : g_col
        logic [127:0] sub_buf_q, sub_buf_d;

        always_comb begin
            sb_in = data_q[127:96];
            for (int c = 0; c < 4; c++) begin
                if (col_ctr_q == 2'(c)) sb_in = data_q[127-32*c -: 32];
            end
        end

        // The buffer view includes the column substituted this cycle, so the
        // col 3 cycle sees the complete SubBytes result.
        always_comb begin
            sub_buf_d = sub_buf_q;
            for (int c = 0; c < 4; c++) begin
                if (col_ctr_q == 2'(c)) sub_buf_d[127-32*c -: 32] = sb_out;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sub_buf_q <= '0;
            end else if (state_q == ST_ROUND) begin
                sub_buf_q <= sub_buf_d;
            end
        end

        assign sub_full   = sub_buf_d;
        assign round_step = (col_ctr_q == 2'd3);
    end else begin : g_bad
        $error("aes_encipher_iter: SBOX_PAR must be 16 or 4");
    end

    always_comb begin
        shifted = '0;
        mixed   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-32*c-8*r -: 8] = sub_full[127-32*((c+r)%4)-8*r -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mixcolumn_word(shifted[127-32*c -: 32]);
        end
        round_out = ((round_ctr_q == nr) ? shifted : mixed) ^ round_key;
    end

    always_comb begin
        state_d     = state_q;
        keylen_d    = keylen_q;
        block_d     = block_q;
        data_d      = data_q;
        round_ctr_d = round_ctr_q;
        col_ctr_d   = col_ctr_q;
        valid_d     = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (next) begin
                    block_d  = block;
                    keylen_d = keylen_e'(keylen);
                    valid_d  = 1'b0;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                data_d      = block_q ^ round_key;
                round_ctr_d = 4'd1;
                col_ctr_d   = 2'd0;
                state_d     = ST_ROUND;
            end
            ST_ROUND: begin
                col_ctr_d = round_step ? 2'd0 : col_ctr_q + 2'd1;
                if (round_step) begin
                    data_d = round_out;
                    if (round_ctr_q == nr) begin
                        state_d = ST_DONE;
                    end else begin
                        round_ctr_d = round_ctr_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            keylen_q    <= KEYLEN_128;
            block_q     <= '0;
            data_q      <= '0;
            round_ctr_q <= 4'd0;
            col_ctr_q   <= 2'd0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            keylen_q    <= keylen_d;
            block_q     <= block_d;
            data_q      <= data_d;
            round_ctr_q <= round_ctr_d;
            col_ctr_q   <= col_ctr_d;
            valid_q     <= valid_d;
        end
    end

    assign round        = (state_q == ST_ROUND) ? round_ctr_q : 4'd0;
    assign new_block    = data_q;
    assign ready        = (state_q == ST_IDLE);
    assign result_valid = valid_q;

endmodule

// File: tb/tb_aes_encipher_iter.sv
// Bench for aes_encipher_iter: one 16-lane and one 4-lane instance run side by side
// against an array-based AES model with its own key expansion.
module tb_aes_encipher_iter;

    logic         clk;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [127:0] block;

    logic [3:0]   round16, round4;
    logic [127:0] rk16, rk4, nb16, nb4;
    logic         rdy16, rdy4, rv16, rv4;

    logic [127:0] rk_mem [0:15];
    int           sbox_t [256];
    int           tr16 [200];
    int           tr4 [200];

    int checks;
    int errors;

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    assign rk16 = rk_mem[round16];
    assign rk4  = rk_mem[round4];

    aes_encipher_iter #(.SBOX_PAR(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .block(block),
        .round(round16), .round_key(rk16), .new_block(nb16), .ready(rdy16),
        .result_valid(rv16)
    );

    aes_encipher_iter #(.SBOX_PAR(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .block(block),
        .round(round4), .round_key(rk4), .new_block(nb4), .ready(rdy4),
        .result_valid(rv4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 'hff;
    endfunction

    function automatic int xt(input int a);
        int v;
        v = a << 1;
        if (v > 255) v = v ^ 'h11b;
        return v;
    endfunction

    // S-box table from the generator-3 walk of the multiplicative group.
    task automatic build_sbox();
        int p, q, x;
        p = 1;
        q = 1;
        do begin
            p = (p ^ (p << 1) ^ (((p & 'h80) != 0) ? 'h1b : 0)) & 'hff;
            q = (q ^ (q << 1)) & 'hff;
            q = (q ^ (q << 2)) & 'hff;
            q = (q ^ (q << 4)) & 'hff;
            if ((q & 'h80) != 0) q = q ^ 'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = (x ^ 'h63) & 'hff;
        end while (p != 1);
        sbox_t[0] = 'h63;
    endtask

    function automatic logic [31:0] subword(input logic [31:0] v);
        logic [31:0] o;
        for (int b = 0; b < 4; b++) o[8*b +: 8] = 8'(sbox_t[v[8*b +: 8]]);
        return o;
    endfunction

    task automatic expand_key(input logic [255:0] key, input bit kl);
        logic [31:0] w [0:59];
        logic [31:0] t;
        int nk, nr, rc;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 1;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc[7:0], 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_mem[r] = '0;
        for (int r = 0; r <= nr; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input int nr);
        int s [4][4];
        int t [4][4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = int'(pt[127-32*c-8*r -: 8]) ^ int'(rk_mem[0][127-32*c-8*r -: 8]);
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = sbox_t[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rnd < nr)
                        s[r][c] = xt(t[r][c]) ^ xt(t[(r+1)%4][c]) ^ t[(r+1)%4][c]
                                ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                    s[r][c] = s[r][c] ^ int'(rk_mem[rnd][127-32*c-8*r -: 8]);
                end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = 8'(s[r][c]);
        return o;
    endfunction

    // Drives one start and collects observations; comparisons live in the test tasks.
    task automatic run_op(input logic [127:0] pt, input bit kl, input int pulse_cyc,
                          input bit mutate, output int lat16, output int lat4,
                          output logic [127:0] ct16, output logic [127:0] ct4,
                          output logic v16, output logic v4);
        lat16 = -1;
        lat4  = -1;
        ct16  = 'x;
        ct4   = 'x;
        v16   = 1'bx;
        v4    = 1'bx;
        @(negedge clk);
        next   = 1'b1;
        block  = pt;
        keylen = kl;
        for (int cyc = 0; cyc < 200 && (lat16 < 0 || lat4 < 0); cyc++) begin
            @(negedge clk);
            if (cyc == 0) next = 1'b0;
            if (cyc == pulse_cyc) begin
                next   = 1'b1;
                block  = ~pt;
                keylen = ~kl;
            end else if (cyc == pulse_cyc + 1) begin
                next = 1'b0;
            end
            if (mutate && cyc == 1) begin
                block  = {$urandom, $urandom, $urandom, $urandom};
                keylen = ~kl;
            end
            tr16[cyc] = int'(round16);
            tr4[cyc]  = int'(round4);
            if (lat16 < 0 && rdy16) begin
                lat16 = cyc;
                ct16  = nb16;
                v16   = rv16;
            end
            if (lat4 < 0 && rdy4) begin
                lat4 = cyc;
                ct4  = nb4;
                v4   = rv4;
            end
        end
        next = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (rdy16 !== 1'b1 || rv16 !== 1'b0 || nb16 !== 128'h0 || round16 !== 4'd0) begin
            errors++;
            $display("FAIL reset16: ready=%b valid=%b round=%0d block=%h required ready=1 valid=0 round=0 block=0",
                     rdy16, rv16, round16, nb16);
        end
        checks++;
        if (rdy4 !== 1'b1 || rv4 !== 1'b0 || nb4 !== 128'h0 || round4 !== 4'd0) begin
            errors++;
            $display("FAIL reset4: ready=%b valid=%b round=%0d block=%h required ready=1 valid=0 round=0 block=0",
                     rdy4, rv4, round4, nb4);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rdy16 !== 1'b1 || rdy4 !== 1'b1 || rv16 !== 1'b0 || rv4 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: ready16=%b ready4=%b valid16=%b valid4=%b required 1 1 0 0",
                     rdy16, rdy4, rv16, rv4);
        end
    endtask

    task automatic test_fips_c1();
        int l16, l4, e;
        logic [127:0] c16, c4;
        logic v16, v4;
        expand_key(KEY_C1, 1'b0);
        run_op(PT_FIPS, 1'b0, -1, 1'b0, l16, l4, c16, c4, v16, v4);
        checks++;
        if (c16 !== CT_C1 || v16 !== 1'b1) begin
            errors++;
            $display("FAIL c1_ct16: got %h valid=%b required %h valid=1", c16, v16, CT_C1);
        end
        checks++;
        if (c4 !== CT_C1 || v4 !== 1'b1) begin
            errors++;
            $display("FAIL c1_ct4: got %h valid=%b required %h valid=1", c4, v4, CT_C1);
        end
        checks++;
        if (l16 != 12 || l4 != 42) begin
            errors++;
            $display("FAIL c1_latency: got %0d/%0d required 12/42", l16, l4);
        end
        for (int cyc = 0; cyc <= 12 && l16 == 12; cyc++) begin
            e = (cyc >= 1 && cyc <= 10) ? cyc : 0;
            checks++;
            if (tr16[cyc] != e) begin
                errors++;
                $display("FAIL c1_round16_trace: cycle %0d round=%0d required %0d", cyc, tr16[cyc], e);
            end
        end
        for (int cyc = 0; cyc <= 42 && l4 == 42; cyc++) begin
            e = (cyc >= 1 && cyc <= 40) ? ((cyc - 1) / 4 + 1) : 0;
            checks++;
            if (tr4[cyc] != e) begin
                errors++;
                $display("FAIL c1_round4_trace: cycle %0d round=%0d required %0d", cyc, tr4[cyc], e);
            end
        end
    endtask

    task automatic test_fips_c3();
        int l16, l4;
        logic [127:0] c16, c4;
        logic v16, v4;
        expand_key(KEY_C3, 1'b1);
        run_op(PT_FIPS, 1'b1, -1, 1'b0, l16, l4, c16, c4, v16, v4);
        checks++;
        if (c16 !== CT_C3 || c4 !== CT_C3) begin
            errors++;
            $display("FAIL c3_ct: got %h / %h required %h", c16, c4, CT_C3);
        end
        checks++;
        if (l16 != 16 || l4 != 58) begin
            errors++;
            $display("FAIL c3_latency: got %0d/%0d required 16/58", l16, l4);
        end
    endtask

    task automatic test_ignore_next();
        int l16, l4;
        logic [127:0] c16, c4;
        logic v16, v4;
        expand_key(KEY_C1, 1'b0);
        run_op(PT_FIPS, 1'b0, 5, 1'b0, l16, l4, c16, c4, v16, v4);
        checks++;
        if (c16 !== CT_C1 || c4 !== CT_C1) begin
            errors++;
            $display("FAIL busy_next_ct: got %h / %h required %h", c16, c4, CT_C1);
        end
        checks++;
        if (l16 != 12 || l4 != 42) begin
            errors++;
            $display("FAIL busy_next_latency: got %0d/%0d required 12/42", l16, l4);
        end
    endtask

    task automatic test_reset_mid();
        int waited, l16, l4;
        logic [127:0] c16, c4;
        logic v16, v4;
        expand_key(KEY_C1, 1'b0);
        @(negedge clk);
        next   = 1'b1;
        block  = PT_FIPS;
        keylen = 1'b0;
        @(negedge clk);
        next   = 1'b0;
        waited = 0;
        while (round16 !== 4'd6 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (round16 !== 4'd6) begin
            errors++;
            $display("FAIL midreset_wait: round=%0d required 6", round16);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (rdy16 !== 1'b1 || rv16 !== 1'b0 || nb16 !== 128'h0 || rdy4 !== 1'b1 || rv4 !== 1'b0 || nb4 !== 128'h0) begin
            errors++;
            $display("FAIL midreset_outputs: ready=%b/%b valid=%b/%b block=%h/%h required ready=1 valid=0 block=0",
                     rdy16, rdy4, rv16, rv4, nb16, nb4);
        end
        @(negedge clk);
        checks++;
        if (round16 !== 4'd0 || round4 !== 4'd0 || nb16 !== 128'h0) begin
            errors++;
            $display("FAIL midreset_hold: round=%0d/%0d block=%h required 0/0 and 0", round16, round4, nb16);
        end
        reset_n = 1'b1;
        run_op(PT_FIPS, 1'b0, -1, 1'b0, l16, l4, c16, c4, v16, v4);
        checks++;
        if (c16 !== CT_C1 || c4 !== CT_C1 || l16 != 12 || l4 != 42) begin
            errors++;
            $display("FAIL midreset_rerun: got %h / %h lat %0d/%0d required %h lat 12/42",
                     c16, c4, l16, l4, CT_C1);
        end
    endtask

    task automatic test_random();
        int l16, l4, nr;
        logic [127:0] c16, c4, pt, exp_ct;
        logic [255:0] key;
        logic v16, v4;
        bit kl;
        for (int n = 0; n < 6; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            kl  = 1'($urandom_range(0, 1));
            nr  = kl ? 14 : 10;
            expand_key(key, kl);
            exp_ct = model_encrypt(pt, nr);
            run_op(pt, kl, -1, 1'b1, l16, l4, c16, c4, v16, v4);
            checks++;
            if (c16 !== exp_ct || c4 !== exp_ct || v16 !== 1'b1 || v4 !== 1'b1) begin
                errors++;
                $display("FAIL random_ct[%0d]: keylen=%0d got %h / %h valid %b/%b required %h valid 1",
                         n, kl, c16, c4, v16, v4, exp_ct);
            end
            checks++;
            if (l16 != 2 + nr || l4 != 2 + 4 * nr) begin
                errors++;
                $display("FAIL random_latency[%0d]: got %0d/%0d required %0d/%0d",
                         n, l16, l4, 2 + nr, 2 + 4 * nr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic e16, e4;
        int waited;
        expand_key(KEY_C1, 1'b0);
        @(negedge clk);
        next   = 1'b1;
        block  = PT_FIPS;
        keylen = 1'b0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clk);
            e16 = (cyc % 13 == 12);
            e4  = (cyc % 43 == 42);
            checks++;
            if (rdy16 !== e16 || rv16 !== e16) begin
                errors++;
                $display("FAIL b2b_flags16: cycle %0d ready=%b valid=%b required %b %b", cyc, rdy16, rv16, e16, e16);
            end
            checks++;
            if (rdy4 !== e4 || rv4 !== e4) begin
                errors++;
                $display("FAIL b2b_flags4: cycle %0d ready=%b valid=%b required %b %b", cyc, rdy4, rv4, e4, e4);
            end
            if (e16 || (cyc > 0 && cyc % 13 == 0)) begin
                checks++;
                if (nb16 !== CT_C1) begin
                    errors++;
                    $display("FAIL b2b_ct16: cycle %0d got %h required %h", cyc, nb16, CT_C1);
                end
            end
            if (e4) begin
                checks++;
                if (nb4 !== CT_C1) begin
                    errors++;
                    $display("FAIL b2b_ct4: cycle %0d got %h required %h", cyc, nb4, CT_C1);
                end
            end
        end
        next   = 1'b0;
        waited = 0;
        while (!(rdy4 === 1'b1 && rdy16 === 1'b1) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (rdy4 !== 1'b1 || rv4 !== 1'b1 || nb4 !== CT_C1) begin
            errors++;
            $display("FAIL b2b_drain: ready=%b valid=%b block=%h required ready=1 valid=1 block=%h",
                     rdy4, rv4, nb4, CT_C1);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = '0;
        for (int r = 0; r < 16; r++) rk_mem[r] = '0;
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_c3();
        test_ignore_next();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
